// File: rtl/max_pooling_layer_if.sv
// Pixel stream bundle between convolutional_layer and max_pooling_layer.
// The master drives the raw pixel stream; the slave (pooling stage) returns pooled maxima.
interface max_pooling_layer_if #(
  parameter int D_WIDTH = 16
);
  logic [D_WIDTH-1:0] input_data;
  logic               input_valid;
  logic [D_WIDTH-1:0] output_data;
  logic               valid;

  modport master (
    output input_data,
    output input_valid,
    input  output_data,
    input  valid
  );

  modport slave (
    input  input_data,
    input  input_valid,
    output output_data,
    output valid
  );
endinterface

// File: rtl/max_pooling_layer.sv
// Streaming 2x2 / stride-2 max pooling over a raster-order pixel stream.
// Even-row pair maxima wait in a half-width line buffer until the odd row arrives.
module max_pooling_layer #(
  parameter int D_WIDTH    = 16,
  parameter int IMAGE_SIZE = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  max_pooling_layer_if.slave bus
);
  localparam int HALF   = IMAGE_SIZE / 2;
  localparam int CNT_W  = (IMAGE_SIZE > 2) ? $clog2(IMAGE_SIZE) : 1;
  localparam int ADDR_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CNT_W-1:0]   col_reg;
  logic [CNT_W-1:0]   row_reg;
  logic [D_WIDTH-1:0] pair_reg;
  logic [D_WIDTH-1:0] out_reg;
  logic               valid_reg;
  logic [D_WIDTH-1:0] rd_reg;
  logic [D_WIDTH-1:0] line_buf [HALF];

  logic               accept;
  logic               col_odd;
  logic               row_odd;
  logic               col_last;
  logic               row_last;
  logic [ADDR_W-1:0]  buf_addr;
  logic [D_WIDTH-1:0] hmax;
  logic [D_WIDTH-1:0] blk_max;

  assign accept   = clk_en && bus.input_valid;
  assign col_odd  = col_reg[0];
  assign row_odd  = row_reg[0];
  assign col_last = (col_reg == CNT_W'(IMAGE_SIZE - 1));
  assign row_last = (row_reg == CNT_W'(IMAGE_SIZE - 1));
  assign buf_addr = ADDR_W'(col_reg >> 1);
  assign hmax     = (pair_reg > bus.input_data) ? pair_reg : bus.input_data;
  assign blk_max  = (rd_reg > hmax) ? rd_reg : hmax;

  // Raster position counters; the frame wraps with no idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= row_last ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_reg  <= '0;
      out_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (clk_en) begin
      valid_reg <= 1'b0;
      if (accept) begin
        if (!col_odd) begin
          pair_reg <= bus.input_data;
        end else if (row_odd) begin
          out_reg   <= blk_max;
          valid_reg <= 1'b1;
        end
      end
    end
  end

  // Block-RAM style buffer with a registered read. On odd rows the entry is
  // fetched during the even-column accept, one accept ahead of its use, so a
  // read and a write never touch the buffer in the same cycle.
  always_ff @(posedge clk) begin
    if (accept && col_odd && !row_odd) begin
      line_buf[buf_addr] <= hmax;
    end
    if (accept && !col_odd && row_odd) begin
      rd_reg <= line_buf[buf_addr];
    end
  end

  assign bus.output_data = out_reg;
  assign bus.valid       = valid_reg;
endmodule

// File: tb/tb_max_pooling_layer.sv
// Scoreboard bench for max_pooling_layer: a frame-store reference model pushes
// each expected 2x2 maximum when its bottom-right pixel is driven.
module tb_max_pooling_layer;
  localparam int DW = 16;
  localparam int N  = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;

  max_pooling_layer_if #(.D_WIDTH(DW)) bus ();

  max_pooling_layer #(.D_WIDTH(DW), .IMAGE_SIZE(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] frame_mem [N][N];

  int            pulse_cnt;
  int            ffff_cnt;
  int            nonzero_cnt;
  logic [DW-1:0] first_out;
  logic [DW-1:0] last_out;
  logic [DW-1:0] max_seen;

  logic          last_acc;
  logic          last_en;
  logic [DW-1:0] prev_out;
  logic          prev_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // mode 0: ramp, 1: all ones, 2..5: zero frame with one {5,9,3,7} block, 9 at slot mode-2
  function automatic logic [DW-1:0] pix(input int mode, input int r, input int c);
    int idx;
    int k;
    int j;
    if (mode == 0) return DW'(r * N + c);
    if (mode == 1) return 16'hFFFF;
    if (r < 10 || r > 11 || c < 20 || c > 21) return '0;
    k   = mode - 2;
    idx = (r - 10) * 2 + (c - 20);
    if (idx == k) return 16'd9;
    j = (idx < k) ? idx : idx - 1;
    case (j)
      0:       return 16'd5;
      1:       return 16'd3;
      default: return 16'd7;
    endcase
  endfunction

  task automatic drive_cycle(input logic en, input logic iv, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    clk_en          = en;
    bus.input_valid = iv;
    bus.input_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b1, 1'b0, '0);
  endtask

  // Drives one frame; stops before (stop_r, stop_c) when given, freezes clk_en
  // for 10 cycles before (frz_r, frz_c) when given.
  task automatic send_frame(input int mode, input bit toggle, input int frz_r, input int frz_c,
                            input int stop_r, input int stop_c);
    logic [DW-1:0] v;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (r == stop_r && c == stop_c) return;
        v = pix(mode, r, c);
        if (r == frz_r && c == frz_c) begin
          repeat (10) drive_cycle(1'b0, 1'b1, 16'h1234);
        end
        if (toggle) drive_cycle(1'b1, 1'b0, 16'hBEEF);
        drive_cycle(1'b1, 1'b1, v);
        frame_mem[r][c] = v;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          exp_q.push_back(max4(frame_mem[r-1][c-1], frame_mem[r-1][c], frame_mem[r][c-1], v));
        end
      end
    end
  endtask

  task automatic clear_stats();
    pulse_cnt   = 0;
    ffff_cnt    = 0;
    nonzero_cnt = 0;
    max_seen    = '0;
    first_out   = '0;
    last_out    = '0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_acc   = 1'b0;
      last_en    = 1'b1;
      prev_out   = bus.output_data;
      prev_valid = bus.valid;
    end else begin
      if (!last_en) begin
        check("frozen_data", bus.output_data, prev_out);
        check("frozen_valid", bus.valid, prev_valid);
      end else if (!last_acc) begin
        check("valid_after_gap", bus.valid, 1'b0);
      end
      if (bus.valid && last_en && last_acc) begin
        if (exp_q.size() == 0) begin
          check("sb_pending", exp_q.size(), 1);
        end else begin
          check("pool", bus.output_data, exp_q.pop_front());
        end
        if (pulse_cnt == 0) first_out = bus.output_data;
        last_out = bus.output_data;
        if (bus.output_data > max_seen) max_seen = bus.output_data;
        if (bus.output_data == 16'hFFFF) ffff_cnt++;
        if (bus.output_data != '0) nonzero_cnt++;
        pulse_cnt++;
      end
      prev_out   = bus.output_data;
      prev_valid = bus.valid;
      last_acc   = clk_en && bus.input_valid;
      last_en    = clk_en;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n           = 1'b0;
    clk_en          = 1'b0;
    bus.input_valid = 1'b0;
    bus.input_data  = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", bus.valid, 1'b0);
    check("reset_data", bus.output_data, '0);
    rst_n = 1'b1;
    idle(2);

    // Ramp frame
    clear_stats();
    send_frame(0, 1'b0, -1, -1, -1, -1);
    idle(3);
    check("t1_pulses", pulse_cnt, 1024);
    check("t1_first", first_out, 16'd65);
    check("t1_last", last_out, 16'd4095);
    check("t1_q_empty", exp_q.size(), 0);

    // Single block with 9 in each of the four positions
    for (int k = 0; k < 4; k++) begin
      clear_stats();
      send_frame(2 + k, 1'b0, -1, -1, -1, -1);
      idle(3);
      check($sformatf("t2_max_%0d", k), max_seen, 16'd9);
      check($sformatf("t2_nonzero_%0d", k), nonzero_cnt, 1);
    end

    // Ramp with input_valid toggling
    clear_stats();
    send_frame(0, 1'b1, -1, -1, -1, -1);
    idle(3);
    check("t3_pulses", pulse_cnt, 1024);
    check("t3_first", first_out, 16'd65);
    check("t3_last", last_out, 16'd4095);

    // clk_en dropped mid row 33, just after an output pulse
    clear_stats();
    send_frame(0, 1'b0, 33, 10, -1, -1);
    idle(3);
    check("t4_pulses", pulse_cnt, 1024);
    check("t4_last", last_out, 16'd4095);
    check("t4_q_empty", exp_q.size(), 0);

    // Asynchronous reset at row 17 col 30 while valid is high
    clear_stats();
    send_frame(0, 1'b0, -1, -1, 17, 30);
    @(posedge clk);
    #2;
    check("t5_valid_before", bus.valid, 1'b1);
    bus.input_valid = 1'b0;
    rst_n           = 1'b0;
    #1;
    check("t5_rst_valid", bus.valid, 1'b0);
    check("t5_rst_data", bus.output_data, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_stats();
    send_frame(0, 1'b0, -1, -1, -1, -1);
    idle(3);
    check("t5_first", first_out, 16'd65);
    check("t5_pulses", pulse_cnt, 1024);

    // Back-to-back frames, second saturated
    clear_stats();
    send_frame(0, 1'b0, -1, -1, -1, -1);
    send_frame(1, 1'b0, -1, -1, -1, -1);
    idle(3);
    check("t6_pulses", pulse_cnt, 2048);
    check("t6_ffff", ffff_cnt, 1024);
    check("t6_last", last_out, 16'hFFFF);
    check("t6_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
